mux8_src_bank: RTL and testbench
================================

Name: mux8_src_bank

Overview:
- Upstream feeder for the 8-way, 16-bit one-hot multiplexer (inputs A..H, select S, output O).
- Holds eight 16-bit source registers that drive A..H directly.
- Converts a 3-bit read address into the registered one-hot select S, with a valid flag.
- Sits between the datapath write-back and the mux; the mux then stays purely combinational.

Parameters:
- WIDTH, 16, data width of each source register and of A..H
- NSRC, 8, number of sources (fixed at 8; the one-hot select is NSRC bits)
- RST_SEL, 0, source index selected after reset (S = 1 << RST_SEL)

Ports:
- CLK  input  1  single system clock, rising-edge
- RST  input  1  reset, synchronous, active-high
- CLR  input  1  synchronous clear of all source registers; S is unaffected
- WE  input  1  write enable
- WADDR  input  3  register index to write (0 = A ... 7 = H)
- WDATA  input  WIDTH  write data
- RVALID  input  1  read request; latch RADDR into S
- RADDR  input  3  source index to select
- HOLD  input  1  stall; freezes S and SVALID, writes still allowed
- A,B,C,D,E,F,G,H  output  WIDTH each  register contents, driven from flops
- S  output  NSRC  one-hot select to the mux
- SVALID  output  1  S reflects an accepted request

Behaviour:
- All state updates on the rising edge of CLK only. No combinational path from any input to any output.
- Reset (RST=1 at an edge):
  - A..H = 0.
  - S = 1 << RST_SEL (8'h01 by default).
  - SVALID = 0.
  - RST overrides CLR, WE, RVALID and HOLD.
- Register priority per edge: RST > CLR > WE.
  - CLR=1: all eight registers = 0 and any same-cycle write is dropped.
  - WE=1 (no RST/CLR): register[WADDR] = WDATA; the other seven hold. Visible on A..H one cycle after the edge.
- Select path, evaluated when not in reset:
  - HOLD=1: S and SVALID hold, regardless of RVALID.
  - HOLD=0, RVALID=1: S = 1 << RADDR and SVALID = 1, one-cycle latency.
  - HOLD=0, RVALID=0: S holds and SVALID = 0 (single-cycle valid pulse per request).
- S is always exactly one-hot, including after reset, CLR and HOLD. S = 0 is never driven.
- Write and select in the same edge, including the same index: both take effect together. The mux output O shows the new WDATA one cycle after the edge (no bypass, no stale cycle).
- Back-to-back RVALID: a new S every cycle, with SVALID held at 1.
- RADDR and WADDR are 3 bits, so every value is legal. No wrap or overflow conditions exist.
- RST asserted mid-stream (during HOLD or pending requests): the reset state is reached at that edge. No request survives reset.
- Register storage is a flop array, not inferred RAM. Outputs are glitch-free register outputs.

Test Plan:
1. Reset, then idle:
   - Expect A..H = 0, S = 8'h01, SVALID = 0.
   - Expect mux O = 0.
2. Load and select H:
   - Write A=5, B=10, C=15, D=20, E=25, F=30, G=35, H=40 (WADDR 0..7, one per cycle).
   - Then RVALID=1, RADDR=7.
   - Next cycle expect S = 8'h80, SVALID = 1, mux O = 40.
   - The following idle cycle expects SVALID = 0 and S = 8'h80 held.
3. Same-cycle write and select:
   - With C=15, drive WE=1, WADDR=2, WDATA=16'hBEEF together with RVALID=1, RADDR=2.
   - Next cycle expect C = 16'hBEEF, S = 8'h04, O = 16'hBEEF.
4. HOLD:
   - With S = 8'h02, set HOLD=1 and RVALID=1, RADDR=5 for 3 cycles.
   - Expect S = 8'h02 and SVALID frozen throughout.
   - Release HOLD with RVALID=1: next cycle S = 8'h20.
5. CLR versus WE:
   - Drive CLR=1 and WE=1, WADDR=4, WDATA=99 in the same cycle.
   - Expect all A..H = 0 (E = 0, not 99) and S unchanged.
6. Reset mid-operation:
   - Assert RST during back-to-back RVALID with RADDR=3,6.
   - Next cycle expect S = 8'h01, SVALID = 0, A..H = 0.
   - Check S is one-hot on every cycle of the run.

Source files
------------

// File: rtl/mux8_src_bank_if.sv
// Handshake/bus bundle between the source bank and its driver: write port,
// read-select request and the registered A..H / one-hot select outputs.
interface mux8_src_bank_if #(
  parameter int WIDTH = 16,
  parameter int NSRC  = 8
);
  logic             CLR;
  logic             WE;
  logic [2:0]       WADDR;
  logic [WIDTH-1:0] WDATA;
  logic             RVALID;
  logic [2:0]       RADDR;
  logic             HOLD;
  logic [WIDTH-1:0] A, B, C, D, E, F, G, H;
  logic [NSRC-1:0]  S;
  logic             SVALID;

  modport master (
    output CLR, WE, WADDR, WDATA, RVALID, RADDR, HOLD,
    input  A, B, C, D, E, F, G, H, S, SVALID
  );

  modport slave (
    input  CLR, WE, WADDR, WDATA, RVALID, RADDR, HOLD,
    output A, B, C, D, E, F, G, H, S, SVALID
  );
endinterface

// File: rtl/mux8_src_bank.sv
// Eight source registers feeding an 8-way one-hot mux, plus the registered
// one-hot select and its single-cycle valid flag.
module mux8_src_bank #(
  parameter int WIDTH   = 16,
  parameter int NSRC    = 8,
  parameter int RST_SEL = 0
) (
  input logic           CLK,
  input logic           RST,
  mux8_src_bank_if.slave bus
);

  localparam logic [NSRC-1:0] RST_S = {{(NSRC-1){1'b0}}, 1'b1} << RST_SEL;

  function automatic logic [NSRC-1:0] to_onehot(input logic [2:0] idx);
    logic [NSRC-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

  logic [WIDTH-1:0] regs_q [NSRC];
  logic [WIDTH-1:0] regs_d [NSRC];
  logic [NSRC-1:0]  sel_q, sel_d;
  logic             svalid_q, svalid_d;

  // Register file next state: CLR wins over any same-cycle write.
  always_comb begin
    regs_d = regs_q;
    if (bus.CLR) begin
      for (int i = 0; i < NSRC; i++) regs_d[i] = '0;
    end else if (bus.WE) begin
      regs_d[bus.WADDR] = bus.WDATA;
    end
  end

  // Select path: S only ever moves to another one-hot value, never to zero.
  always_comb begin
    sel_d    = sel_q;
    svalid_d = svalid_q;
    if (!bus.HOLD) begin
      if (bus.RVALID) begin
        sel_d    = to_onehot(bus.RADDR);
        svalid_d = 1'b1;
      end else begin
        svalid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < NSRC; i++) regs_q[i] <= '0;
      sel_q    <= RST_S;
      svalid_q <= 1'b0;
    end else begin
      regs_q   <= regs_d;
      sel_q    <= sel_d;
      svalid_q <= svalid_d;
    end
  end

  assign bus.A      = regs_q[0];
  assign bus.B      = regs_q[1];
  assign bus.C      = regs_q[2];
  assign bus.D      = regs_q[3];
  assign bus.E      = regs_q[4];
  assign bus.F      = regs_q[5];
  assign bus.G      = regs_q[6];
  assign bus.H      = regs_q[7];
  assign bus.S      = sel_q;
  assign bus.SVALID = svalid_q;

endmodule

// File: tb/tb_mux8_src_bank.sv
// Directed bench for mux8_src_bank: a register-array model checked every
// cycle, plus literal expectations from the hand-worked scenarios.
module tb_mux8_src_bank;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  mux8_src_bank_if #(.WIDTH(16), .NSRC(8)) bus ();

  mux8_src_bank #(.WIDTH(16), .NSRC(8), .RST_SEL(0)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] act_reg(input int i);
    case (i)
      0: return bus.A;
      1: return bus.B;
      2: return bus.C;
      3: return bus.D;
      4: return bus.E;
      5: return bus.F;
      6: return bus.G;
      default: return bus.H;
    endcase
  endfunction

  // What the downstream one-hot mux would present, built from DUT outputs.
  function automatic logic [15:0] mux_o();
    logic [15:0] o;
    o = '0;
    for (int i = 0; i < 8; i++) if (bus.S[i]) o |= act_reg(i);
    return o;
  endfunction

  // Model: contents of the eight sources, index currently selected, valid.
  logic [15:0] m_reg [8];
  int          m_idx  = 0;
  logic        m_sv   = 1'b0;
  logic        m_live = 1'b0;

  always @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < 8; i++) m_reg[i] <= 16'd0;
      m_idx  <= 0;
      m_sv   <= 1'b0;
      m_live <= 1'b1;
    end else begin
      if (bus.CLR) for (int i = 0; i < 8; i++) m_reg[i] <= 16'd0;
      else if (bus.WE) m_reg[bus.WADDR] <= bus.WDATA;
      if (!bus.HOLD) begin
        m_sv <= bus.RVALID;
        if (bus.RVALID) m_idx <= int'(bus.RADDR);
      end
    end
  end

  always @(negedge CLK) begin
    if (m_live) begin
      for (int i = 0; i < 8; i++) chk($sformatf("reg%0d", i), 32'(act_reg(i)), 32'(m_reg[i]));
      chk("S", 32'(bus.S), 32'(1) << m_idx);
      chk("SVALID", 32'(bus.SVALID), 32'(m_sv));
      chk("S_onehot", 32'($onehot(bus.S)), 32'd1);
      chk("O", 32'(mux_o()), 32'(m_reg[m_idx]));
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    bus.CLR = 0; bus.WE = 0; bus.WADDR = 0; bus.WDATA = 0;
    bus.RVALID = 0; bus.RADDR = 0; bus.HOLD = 0;
  endtask

  initial begin
    RST = 1'b1;
    idle();
    tick();
    tick();
    RST = 1'b0;
    // 1: reset state
    chk("rst_S", 32'(bus.S), 32'h01);
    chk("rst_SVALID", 32'(bus.SVALID), 32'd0);
    chk("rst_O", 32'(mux_o()), 32'd0);
    chk("rst_H", 32'(bus.H), 32'd0);
    tick();

    // 2: load A..H = 5,10,...,40 then select H
    for (int i = 0; i < 8; i++) begin
      bus.WE = 1; bus.WADDR = 3'(i); bus.WDATA = 16'(5 * (i + 1));
      tick();
    end
    idle();
    bus.RVALID = 1; bus.RADDR = 3'd7;
    tick();
    chk("selH_S", 32'(bus.S), 32'h80);
    chk("selH_SVALID", 32'(bus.SVALID), 32'd1);
    chk("selH_O", 32'(mux_o()), 32'd40);
    idle();
    tick();
    chk("idle_SVALID", 32'(bus.SVALID), 32'd0);
    chk("idle_S", 32'(bus.S), 32'h80);

    // 3: write and select the same index together
    bus.WE = 1; bus.WADDR = 3'd2; bus.WDATA = 16'hBEEF;
    bus.RVALID = 1; bus.RADDR = 3'd2;
    tick();
    chk("wsel_C", 32'(bus.C), 32'hBEEF);
    chk("wsel_S", 32'(bus.S), 32'h04);
    chk("wsel_O", 32'(mux_o()), 32'hBEEF);
    idle();

    // 4: HOLD freezes S/SVALID but lets writes through
    bus.RVALID = 1; bus.RADDR = 3'd1;
    tick();
    chk("pre_hold_S", 32'(bus.S), 32'h02);
    for (int k = 0; k < 3; k++) begin
      bus.HOLD = 1; bus.RVALID = 1; bus.RADDR = 3'd5;
      bus.WE = (k == 1); bus.WADDR = 3'd6; bus.WDATA = 16'h1234;
      tick();
      chk("hold_S", 32'(bus.S), 32'h02);
      chk("hold_SVALID", 32'(bus.SVALID), 32'd1);
    end
    chk("hold_write_G", 32'(bus.G), 32'h1234);
    idle();
    bus.RVALID = 1; bus.RADDR = 3'd5;
    tick();
    chk("release_S", 32'(bus.S), 32'h20);
    chk("release_O", 32'(mux_o()), 32'd30);
    idle();
    tick();

    // 5: CLR beats a same-cycle write, S untouched
    bus.CLR = 1; bus.WE = 1; bus.WADDR = 3'd4; bus.WDATA = 16'd99;
    tick();
    chk("clr_E", 32'(bus.E), 32'd0);
    chk("clr_B", 32'(bus.B), 32'd0);
    chk("clr_S", 32'(bus.S), 32'h20);
    idle();

    // 6: reset in the middle of back-to-back requests
    bus.WE = 1; bus.WADDR = 3'd3; bus.WDATA = 16'h00A5;
    tick();
    bus.WE = 1; bus.WADDR = 3'd6; bus.WDATA = 16'h5A00;
    bus.RVALID = 1; bus.RADDR = 3'd3;
    tick();
    chk("b2b_S", 32'(bus.S), 32'h08);
    chk("b2b_O", 32'(mux_o()), 32'h00A5);
    bus.WE = 0; bus.RADDR = 3'd6;
    tick();
    chk("b2b_S2", 32'(bus.S), 32'h40);
    chk("b2b_SVALID", 32'(bus.SVALID), 32'd1);
    bus.RADDR = 3'd3; bus.HOLD = 1; bus.WE = 1; bus.WADDR = 3'd0; bus.WDATA = 16'hFFFF;
    RST = 1'b1;
    tick();
    RST = 1'b0;
    chk("mrst_S", 32'(bus.S), 32'h01);
    chk("mrst_SVALID", 32'(bus.SVALID), 32'd0);
    chk("mrst_A", 32'(bus.A), 32'd0);
    chk("mrst_D", 32'(bus.D), 32'd0);
    idle();
    tick();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
